// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: FSM state codes,
// opcode/funct constants, ALU operation enumeration and decode helpers.
package mcpu_pkg;

    typedef enum logic [4:0] {
        S_IF       = 5'd0,
        S_ID       = 5'd1,
        S_MEM_ADDR = 5'd2,
        S_MEM_RD   = 5'd3,
        S_LW_WB    = 5'd4,
        S_MEM_WR   = 5'd5,
        S_R_EXE    = 5'd6,
        S_R_WB     = 5'd7,
        S_BR       = 5'd8,
        S_J        = 5'd9,
        S_I_EXE    = 5'd10,
        S_I_WB     = 5'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_op_t;

    // R-type funct codes the core executes; anything else retires as a NOP.
    function automatic logic funct_supported(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
            FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic alu_op_t alu_op_from_funct(input logic [5:0] fn);
        case (fn)
            FN_SUB, FN_SUBU: return ALU_SUB;
            FN_AND:          return ALU_AND;
            FN_OR:           return ALU_OR;
            FN_XOR:          return ALU_XOR;
            FN_NOR:          return ALU_NOR;
            FN_SLT:          return ALU_SLT;
            FN_SLTU:         return ALU_SLTU;
            FN_SLL:          return ALU_SLL;
            FN_SRL:          return ALU_SRL;
            default:         return ALU_ADD;
        endcase
    endfunction

    function automatic alu_op_t alu_op_from_opcode(input logic [5:0] op);
        case (op)
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational 32-bit ALU. Shifts move operand b by shamt; LUI places the
// low half of b in the upper half of the result. Arithmetic wraps modulo 2^32.
module mcpu_alu
    import mcpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero
);

    // Select the result for the requested operation.
    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {31'd0, (a < b)};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_LUI:  y = {b[15:0], 16'd0};
            default:  y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle MIPS-subset core with one shared instruction/data port.
// Bus handshake: the core holds CPU_MIO=1 with a stable Addr_out (and
// Data_out/mem_w for stores) in IF, MEM_RD and MEM_WR; a transfer completes
// on the rising edge where MIO_ready=1, otherwise the state repeats.
// INT is accepted but has no effect in this revision.
module mcpu_core
    import mcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_ready,
    input  logic        INT,
    input  logic [31:0] Data_in,
    output logic [31:0] PC_out,
    output logic [31:0] inst_out,
    output logic        mem_w,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic        CPU_MIO,
    output logic [4:0]  state
);

    state_t      cur_state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] regs [0:31];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] imm_i;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_t     alu_op;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        branch_taken;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        unused_int;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext = {16'd0, ir[15:0]};
    assign imm_i    = (opcode == OP_ANDI || opcode == OP_ORI ||
                       opcode == OP_XORI || opcode == OP_LUI) ? imm_zext : imm_sext;
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign unused_int = INT;

    // One ALU is time-shared: branch target in ID, address in MEM_ADDR,
    // the operation itself in R_EXE/I_EXE and the A-B compare in BR.
    always_comb begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = ALU_ADD;
        case (cur_state)
            S_ID: begin
                alu_a = pc;
                alu_b = {imm_sext[29:0], 2'b00};
            end
            S_MEM_ADDR: alu_b = imm_sext;
            S_R_EXE:    alu_op = alu_op_from_funct(funct);
            S_I_EXE: begin
                alu_b  = imm_i;
                alu_op = alu_op_from_opcode(opcode);
            end
            S_BR:       alu_op = ALU_SUB;
            default:    alu_op = ALU_ADD;
        endcase
    end

    mcpu_alu u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .shamt (shamt),
        .op    (alu_op),
        .y     (alu_y),
        .zero  (alu_zero)
    );

    assign branch_taken = (opcode == OP_BEQ && alu_zero) ||
                          (opcode == OP_BNE && !alu_zero);

    // Next-state selection; unsupported encodings drop back to IF from ID.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IF:       if (MIO_ready) next_state = S_ID;
            S_ID: begin
                case (opcode)
                    OP_RTYPE: next_state = funct_supported(funct) ? S_R_EXE : S_IF;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BR;
                    OP_J:     next_state = S_J;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                              next_state = S_I_EXE;
                    default:  next_state = S_IF;
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (MIO_ready) next_state = S_LW_WB;
            S_LW_WB:    next_state = S_IF;
            S_MEM_WR:   if (MIO_ready) next_state = S_IF;
            S_R_EXE:    next_state = S_R_WB;
            S_R_WB:     next_state = S_IF;
            S_BR:       next_state = S_IF;
            S_J:        next_state = S_IF;
            S_I_EXE:    next_state = S_I_WB;
            S_I_WB:     next_state = S_IF;
            default:    next_state = S_IF;
        endcase
    end

    // State register with bus strobes registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IF;
            mem_w     <= 1'b0;
            CPU_MIO   <= 1'b1;
        end else begin
            cur_state <= next_state;
            mem_w     <= (next_state == S_MEM_WR);
            CPU_MIO   <= (next_state == S_IF) || (next_state == S_MEM_RD) ||
                         (next_state == S_MEM_WR);
        end
    end

    // Datapath registers: PC, IR, A/B operand latches, ALUOut and MDR.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            case (cur_state)
                S_IF: if (MIO_ready) begin
                    ir <= Data_in;
                    pc <= pc + 32'd4;
                end
                S_ID: begin
                    a_reg   <= rs_val;
                    b_reg   <= rt_val;
                    alu_out <= alu_y;
                end
                S_MEM_ADDR, S_R_EXE, S_I_EXE: alu_out <= alu_y;
                S_MEM_RD: if (MIO_ready) mdr <= Data_in;
                S_BR:     if (branch_taken) pc <= alu_out;
                S_J:      pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Writeback source and destination for the three retiring states.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out;
        case (cur_state)
            S_LW_WB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr;
            end
            S_R_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
            end
            S_I_WB:  rf_we = 1'b1;
            default: rf_we = 1'b0;
        endcase
    end

    // Register file; $0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign PC_out   = pc;
    assign inst_out = ir;
    assign Addr_out = (cur_state == S_IF) ? pc : alu_out;
    assign Data_out = b_reg;
    assign state    = cur_state;

endmodule

// File: tb/tb_mcpu_core.sv
// Testbench for mcpu_core: directed start-up program, R-type sequence,
// branches/jumps, bus stalls, random programs and reset during a load,
// checked against an instruction-level model of the ISA.
module tb_mcpu_core;

    localparam logic [4:0] ST_IF = 5'd0, ST_ID = 5'd1, ST_MA = 5'd2, ST_MR = 5'd3,
                           ST_LWB = 5'd4, ST_MW = 5'd5, ST_REX = 5'd6, ST_RWB = 5'd7,
                           ST_BR = 5'd8, ST_J = 5'd9, ST_IEX = 5'd10, ST_IWB = 5'd11;

    logic        clk = 1'b0;
    logic        reset;
    logic        MIO_ready;
    logic        INT;
    logic [31:0] Data_in;
    logic [31:0] PC_out;
    logic [31:0] inst_out;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        CPU_MIO;
    logic [4:0]  state;

    mcpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .MIO_ready (MIO_ready),
        .INT       (INT),
        .Data_in   (Data_in),
        .PC_out    (PC_out),
        .inst_out  (inst_out),
        .mem_w     (mem_w),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .CPU_MIO   (CPU_MIO),
        .state     (state)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic        pc_indexed;

    assign Data_in = pc_indexed ? mem[PC_out[9:2]] : mem[Addr_out[9:2]];

    always @(posedge clk)
        if (!reset && mem_w && MIO_ready) mem[Addr_out[9:2]] <= Data_out;

    // ---------------- reference model state ----------------
    logic [31:0] ref_regs [32];
    logic [31:0] ref_mem  [256];
    logic [31:0] ref_pc;
    logic [4:0]  exp_q [$];
    logic [31:0] exp_pcb, exp_ins, exp_maddr, exp_wdata;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_bus(input logic [4:0] s);
        return (s == ST_IF) || (s == ST_MR) || (s == ST_MW);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        MIO_ready = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        ref_pc = 32'd0;
    endtask

    // Executes one instruction architecturally and lists its expected states.
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, res;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, wa;
        logic        wr;
        ins = ref_mem[ref_pc[9:2]];
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a  = ref_regs[rs]; b = ref_regs[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'd0, ins[15:0]};
        exp_pcb = ref_pc;
        exp_ins = ins;
        ref_pc  = ref_pc + 32'd4;
        exp_q = {};
        exp_q.push_back(ST_IF);
        exp_q.push_back(ST_ID);
        wr = 1'b0; wa = rt; res = 32'd0;
        case (op)
            6'h00: begin
                wr = 1'b1; wa = rd;
                case (fn)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    default: wr = 1'b0;
                endcase
                if (wr) begin
                    exp_q.push_back(ST_REX);
                    exp_q.push_back(ST_RWB);
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                wr = 1'b1;
                case (op)
                    6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                    6'h0C: res = a & ze;
                    6'h0D: res = a | ze;
                    6'h0E: res = a ^ ze;
                    6'h0F: res = {ins[15:0], 16'd0};
                    default: res = a + se;
                endcase
                exp_q.push_back(ST_IEX);
                exp_q.push_back(ST_IWB);
            end
            6'h23: begin
                exp_maddr = a + se;
                res = ref_mem[exp_maddr[9:2]];
                wr = 1'b1;
                exp_q.push_back(ST_MA);
                exp_q.push_back(ST_MR);
                exp_q.push_back(ST_LWB);
            end
            6'h2B: begin
                exp_maddr = a + se;
                exp_wdata = b;
                ref_mem[exp_maddr[9:2]] = b;
                exp_q.push_back(ST_MA);
                exp_q.push_back(ST_MW);
            end
            6'h04: begin
                exp_q.push_back(ST_BR);
                if (a == b) ref_pc = ref_pc + (se << 2);
            end
            6'h05: begin
                exp_q.push_back(ST_BR);
                if (a != b) ref_pc = ref_pc + (se << 2);
            end
            6'h02: begin
                exp_q.push_back(ST_J);
                ref_pc = {ref_pc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        if (wr && wa != 5'd0) ref_regs[wa] = res;
    endtask

    // Runs one instruction on the DUT, inserting random bus stalls, and
    // compares every cycle plus the architectural state at retirement.
    task automatic run_instr(input int min_stall, input int max_stall);
        logic [4:0]  st;
        logic [31:0] exp_pc_now;
        int          stalls;
        logic        bad;
        int          bad_i;
        model_step();
        bad = 1'b0;
        while (exp_q.size() > 0) begin
            st = exp_q.pop_front();
            stalls = is_bus(st) ? int'($urandom_range(max_stall, min_stall)) : 0;
            for (int k = 0; k <= stalls; k++) begin
                MIO_ready = (k == stalls);
                exp_pc_now = (st == ST_IF) ? exp_pcb : exp_pcb + 32'd4;
                if (!bad && (state !== st || PC_out !== exp_pc_now ||
                             mem_w !== (st == ST_MW) || CPU_MIO !== is_bus(st) ||
                             (st == ST_IF && Addr_out !== exp_pcb) ||
                             ((st == ST_MR || st == ST_MW) && Addr_out !== exp_maddr) ||
                             (st == ST_MW && Data_out !== exp_wdata))) begin
                    bad = 1'b1;
                    $display("FAIL cycle ins=%h pc=%h: state %0d exp %0d, PC %h exp %h, mem_w %b, CPU_MIO %b, Addr %h, Data_out %h",
                             exp_ins, exp_pcb, state, st, PC_out, exp_pc_now, mem_w, CPU_MIO, Addr_out, Data_out);
                end
                tick();
            end
        end
        MIO_ready = 1'b1;
        checks++;
        if (bad) errors++;
        checks++;
        if (PC_out !== ref_pc) begin
            errors++;
            $display("FAIL retire_pc ins=%h got %h exp %h", exp_ins, PC_out, ref_pc);
        end
        checks++;
        if (inst_out !== exp_ins) begin
            errors++;
            $display("FAIL retire_ir got %h exp %h", inst_out, exp_ins);
        end
        bad_i = -1;
        for (int i = 0; i < 32; i++)
            if (bad_i < 0 && dut.regs[i] !== ref_regs[i]) bad_i = i;
        checks++;
        if (bad_i >= 0) begin
            errors++;
            $display("FAIL regfile ins=%h r%0d got %h exp %h", exp_ins, bad_i,
                     dut.regs[bad_i], ref_regs[bad_i]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn_list [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                     6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};
        logic [5:0] op_list [7] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        int k;
        k  = int'($urandom_range(20, 0));
        rs = 5'($urandom_range(7, 0));
        rt = 5'($urandom_range(7, 0));
        rd = 5'($urandom_range(7, 0));
        sh = 5'($urandom);
        imm = 16'($urandom);
        if (k < 8)       return {6'h00, rs, rt, rd, sh, fn_list[$urandom_range(11, 0)]};
        else if (k < 13) return {op_list[$urandom_range(6, 0)], rs, rt, imm};
        else if (k < 15) return {6'h23, rs, rt, imm};
        else if (k < 17) return {6'h2B, rs, rt, imm};
        else if (k < 19) return {(k == 17) ? 6'h04 : 6'h05, rs, rt,
                                 16'($signed(int'($urandom_range(8, 0)) - 4))};
        else if (k < 20) return {6'h02, 18'd0, 8'($urandom)};
        else             return {6'h3F, rs, rt, imm};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad_i;
        pc_indexed = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'h0000_4027;
        mem[1] = 32'h0000_4820;
        mem[2] = 32'h8D2A_0004;
        mem[3] = 32'hAD09_0000;
        INT = 1'b0;
        do_reset();
        checks++;
        if (state !== ST_IF || PC_out !== 32'd0 || Addr_out !== 32'd0 || CPU_MIO !== 1'b1) begin
            errors++;
            $display("FAIL reset_out state %0d PC %h Addr %h CPU_MIO %b exp 0/0/0/1",
                     state, PC_out, Addr_out, CPU_MIO);
        end
        checks++;
        if (mem_w !== 1'b0 || inst_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_misc mem_w %b IR %h exp 0/0", mem_w, inst_out);
        end
        bad_i = -1;
        for (int i = 0; i < 32; i++) if (bad_i < 0 && dut.regs[i] !== 32'd0) bad_i = i;
        checks++;
        if (bad_i >= 0) begin
            errors++;
            $display("FAIL reset_regs r%0d got %h exp 0", bad_i, dut.regs[bad_i]);
        end
    endtask

    task automatic test_startup_program();
        int wr_cycles;
        repeat (4) tick();
        checks++;
        if (dut.regs[8] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL nor_t0 got %h exp FFFFFFFF", dut.regs[8]);
        end
        repeat (4) tick();
        checks++;
        if (dut.regs[9] !== 32'd0 || PC_out !== 32'h8) begin
            errors++;
            $display("FAIL add_t1 got %h PC %h exp 0/8", dut.regs[9], PC_out);
        end
        repeat (3) tick();
        checks++;
        if (state !== ST_MR || Addr_out !== 32'h4 || CPU_MIO !== 1'b1 || mem_w !== 1'b0) begin
            errors++;
            $display("FAIL lw_memrd state %0d Addr %h CPU_MIO %b mem_w %b exp 3/4/1/0",
                     state, Addr_out, CPU_MIO, mem_w);
        end
        repeat (2) tick();
        checks++;
        if (dut.regs[10] !== 32'hAD09_0000 || inst_out !== 32'h8D2A_0004) begin
            errors++;
            $display("FAIL lw_t2 got %h IR %h exp AD090000/8D2A0004", dut.regs[10], inst_out);
        end
        tick();
        checks++;
        if (PC_out !== 32'h10) begin
            errors++;
            $display("FAIL sw_pc got %h exp 10", PC_out);
        end
        wr_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            if (mem_w === 1'b1) begin
                wr_cycles++;
                checks++;
                if (Addr_out !== 32'hFFFF_FFFF || Data_out !== 32'd0) begin
                    errors++;
                    $display("FAIL sw_bus Addr %h Data %h exp FFFFFFFF/0", Addr_out, Data_out);
                end
            end
            tick();
        end
        checks++;
        if (wr_cycles != 1 || state !== ST_IF) begin
            errors++;
            $display("FAIL sw_once mem_w cycles %0d state %0d exp 1/0", wr_cycles, state);
        end
    endtask

    task automatic test_rtype_seq();
        logic [31:0] prog [7] = '{32'h0128_5020, 32'h0149_5822, 32'h014B_6024, 32'h014B_6025,
                                  32'h014B_6026, 32'h014B_782A, 32'h000A_8000};
        for (int i = 0; i < 7; i++) mem[4 + i] = prog[i];
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_regs[8]  = 32'hFFFF_FFFF;
        ref_regs[10] = 32'hAD09_0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        ref_pc = 32'h10;
        pc_indexed = 1'b0;
        for (int i = 0; i < 7; i++) run_instr(0, 0);
        checks++;
        if (dut.regs[16] !== 32'hFFFF_FFFF || dut.regs[12] !== 32'd0) begin
            errors++;
            $display("FAIL sll_s0 s0 %h t4 %h exp FFFFFFFF/0", dut.regs[16], dut.regs[12]);
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] filler = 32'h2009_0063;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'h2001_0005;  mem[1] = 32'h2002_0005;  mem[2] = 32'h1022_0002;
        mem[3] = filler;         mem[4] = filler;         mem[5] = 32'h1422_0003;
        mem[6] = 32'h1020_0003;  mem[7] = 32'h1420_0001;  mem[8] = filler;
        mem[9] = 32'h0800_0010;
        mem[16] = 32'h3C03_8000; mem[17] = 32'h2864_0001; mem[18] = 32'h3465_F0F0;
        mem[19] = 32'hFC00_0000; mem[20] = 32'h0083_302B; mem[21] = 32'h0003_3902;
        mem[22] = 32'hAC03_0100; mem[23] = 32'h8C08_0100;
        do_reset();
        repeat (3) run_instr(0, 0);
        checks++;
        if (PC_out !== 32'h14) begin
            errors++;
            $display("FAIL beq_taken PC got %h exp 14", PC_out);
        end
        run_instr(0, 0);
        run_instr(0, 0);
        checks++;
        if (PC_out !== 32'h1C) begin
            errors++;
            $display("FAIL br_not_taken PC got %h exp 1C", PC_out);
        end
        run_instr(0, 0);
        checks++;
        if (PC_out !== 32'h24) begin
            errors++;
            $display("FAIL bne_taken PC got %h exp 24", PC_out);
        end
        run_instr(0, 0);
        checks++;
        if (PC_out !== 32'h40) begin
            errors++;
            $display("FAIL j_target PC got %h exp 40", PC_out);
        end
        repeat (6) run_instr(0, 0);
    endtask

    task automatic test_stall();
        run_instr(1, 3);
        run_instr(1, 3);
        checks++;
        if (dut.regs[8] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL stall_lw r8 got %h exp 80000000", dut.regs[8]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) mem[i] = rand_instr();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            INT = 1'($urandom);
            run_instr(0, 2);
        end
        INT = 1'b0;
    endtask

    task automatic test_reset_mid_lw();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'h8C05_0000;
        do_reset();
        repeat (3) tick();
        MIO_ready = 1'b0;
        tick();
        checks++;
        if (state !== ST_MR || PC_out !== 32'h4) begin
            errors++;
            $display("FAIL lw_stall_hold state %0d PC %h exp 3/4", state, PC_out);
        end
        reset = 1'b1;
        MIO_ready = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (state !== ST_IF || PC_out !== 32'd0 || mem_w !== 1'b0 || CPU_MIO !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_lw state %0d PC %h mem_w %b CPU_MIO %b exp 0/0/0/1",
                     state, PC_out, mem_w, CPU_MIO);
        end
        tick();
        checks++;
        if (dut.regs[5] !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_wb r5 got %h exp 0", dut.regs[5]);
        end
        // Restart from a clean reference: the aborted load is re-fetched.
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_pc = 32'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_instr(0, 1);
    endtask

    initial begin
        reset = 1'b1;
        MIO_ready = 1'b1;
        INT = 1'b0;
        pc_indexed = 1'b1;
        test_reset();
        test_startup_program();
        test_rtype_seq();
        test_branch_jump();
        test_stall();
        test_random();
        test_reset_mid_lw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcpu_core.md
Name: mcpu_core

Overview:
- Multi-cycle 32-bit MIPS-subset CPU core with a single shared instruction/data memory port.
- Sits between the SoC clock/reset and the memory/IO bus.
- Each instruction steps through a 5-bit-encoded control FSM: fetch, decode, execute, memory, writeback.
- Exposes PC, instruction register and FSM state for debug and display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears the core.
- MIO_ready  in  1  memory/IO ready; while 0, memory-access states stall.
- INT  in  1  interrupt request; reserved, ignored by this revision.
- Data_in  in  32  read data from memory/IO (instruction in fetch, load data in MEM_RD).
- PC_out  out  32  current PC register.
- inst_out  out  32  instruction register (IR).
- mem_w  out  1  memory write strobe; 1 only in MEM_WR.
- Addr_out  out  32  memory address: PC in IF, ALUOut in MEM_RD/MEM_WR, else ALUOut.
- Data_out  out  32  store data = register B (rt value latched in ID).
- CPU_MIO  out  1  bus request; 1 in IF, MEM_RD, MEM_WR.
- state  out  5  current FSM state code.

Behaviour:
- Reset (synchronous, high):
  - PC=RESET_PC, IR=0, A/B/ALUOut/MDR=0, all 32 registers=0, state=IF.
  - Outputs: mem_w=0; CPU_MIO=1 (IF); Addr_out=PC.
  - Reset mid-instruction aborts it; no partial register or memory write.
- Register file: 32x32; $0 reads 0; writes to $0 are discarded.
- States (code):
  - IF=0: Addr_out=PC. If MIO_ready, IR<=Data_in, PC<=PC+4, go ID; else hold.
  - ID=1: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode.
  - MEM_ADDR=2: ALUOut<=A+sext(imm). lw goes MEM_RD; sw goes MEM_WR.
  - MEM_RD=3: when MIO_ready, MDR<=Data_in, go LW_WB; else hold.
  - LW_WB=4: R[rt]<=MDR, go IF.
  - MEM_WR=5: mem_w=1; when MIO_ready, go IF; else hold with mem_w=1.
  - R_EXE=6: ALUOut<=A op B (funct).
  - R_WB=7: R[rd]<=ALUOut, go IF.
  - BR=8: if (A==B) for beq, or (A!=B) for bne, PC<=ALUOut; go IF.
  - J=9: PC<={PC[31:28],target,2'b00}; go IF.
  - I_EXE=10: ALUOut<=A op imm.
  - I_WB=11: R[rt]<=ALUOut, go IF.
  - Unsupported opcode/funct: treat as NOP (ID goes to IF).
- R-type funct set:
  - add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A (signed), sltu 2B.
  - sll 00, srl 02: shamt, operand B.
  - No overflow traps.
- I-type opcode set:
  - addi 08, addiu 09, slti 0A: sign-extended immediate.
  - andi 0C, ori 0D, xori 0E: zero-extended immediate.
  - lui 0F: imm<<16.
  - lw 23, sw 2B, beq 04, bne 05, j 02.
- Latency: R/I-type 4 cycles, lw 5, sw 4, branch 3, j 3, each plus stall cycles.
- Arithmetic is 32-bit modulo; addresses are not alignment-checked.

Decomposition:
- Shared package holds:
  - state codes (5-bit);
  - opcode constants;
  - funct constants;
  - ALU-op enumeration.
- Sub-modules:
  - mcpu_alu: combinational, 32-bit, ALU-op input, zero flag.
  - Register file and FSM/datapath stay in the top.

Test Plan:
- Reset held 100 ns, MIO_ready=1, release; memory returns by PC: 0→00004027, 4→00004820, 8→8D2A0004, C→AD090000.
  - First cycle: state=0, PC_out=0, Addr_out=0, CPU_MIO=1.
  - nor retires: $t0=FFFFFFFF; add retires: $t1=0.
- lw $t2,4($t1): in MEM_RD, Addr_out=4, CPU_MIO=1, mem_w=0. Data_in there is 0xAD090000, so $t2=AD090000 after LW_WB; inst_out=8D2A0004.
- sw $t1,0($t0): exactly one MEM_WR cycle with mem_w=1, Addr_out=FFFFFFFF, Data_out=00000000; PC_out=10 after fetch.
- R-type ALU sequence, checking rd each R_WB:
  - add (01285020), sub (01495822), and/or/xor (014B6024/25/26), slt (014B782A);
  - sll 000A8000: $s0=$t2.
- MIO_ready=0 during IF/MEM_RD/MEM_WR: state, PC_out and mem_w hold; resume the cycle after ready=1.
- beq taken/not-taken, bne, j target: PC_out matches the required target. Assert reset mid-lw: state=0, PC_out=0, no register write.
